// File: rtl/ad_responder_if.sv
// ad_responder_if
// Groups the responder's A/D-converter lanes and its sample-feed handshake.
//   slave  modport : used by ad_responder (the converter emulator)
//   master modport : used by whatever drives ad_cs and the sample stream
// Signals:
//   ad_cs                 chip-select from the reader, active low
//   ad_sdata_a/b [1:0]    serial lanes; [0] carries a0/b0, [1] carries a1/b1
//   sample_a0..b1         next sample set
//   sample_valid/ready    one-deep buffered handshake
//   frame_done, underrun  one-cycle status pulses
//   frame_count           completed frames (wraps)
//   abort_count           frames cut short by ad_cs (saturates)
interface ad_responder_if #(
    parameter int DATA_BITS = 12,
    parameter int FCNT_W    = 16
);
    logic                 ad_cs;
    logic [1:0]           ad_sdata_a;
    logic [1:0]           ad_sdata_b;
    logic [DATA_BITS-1:0] sample_a0;
    logic [DATA_BITS-1:0] sample_a1;
    logic [DATA_BITS-1:0] sample_b0;
    logic [DATA_BITS-1:0] sample_b1;
    logic                 sample_valid;
    logic                 sample_ready;
    logic                 frame_done;
    logic                 underrun;
    logic [FCNT_W-1:0]    frame_count;
    logic [7:0]           abort_count;

    modport slave (
        input  ad_cs, sample_a0, sample_a1, sample_b0, sample_b1, sample_valid,
        output ad_sdata_a, ad_sdata_b, sample_ready, frame_done, underrun,
               frame_count, abort_count
    );

    modport master (
        output ad_cs, sample_a0, sample_a1, sample_b0, sample_b1, sample_valid,
        input  ad_sdata_a, ad_sdata_b, sample_ready, frame_done, underrun,
               frame_count, abort_count
    );
endinterface

// File: rtl/ad_responder.sv
// ad_responder
// Slave-side emulator of a dual-lane serial A/D converter pair. On each
// falling ad_cs it serialises four samples (a0, a1, b0, b1) MSB first after
// LEAD_ZEROS zero bits, all four lanes bit-aligned. Sample sets arrive through
// a one-deep staging register with a valid/ready handshake.
// Ports:
//   clk      system clock (the reader samples sdata on the opposite edge)
//   reset_n  asynchronous active-low reset
//   bus      ad_responder_if.slave, lanes + handshake + status
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | lanes 0, waiting for ad_cs falling (cs_d=1, ad_cs=0)
// S_SHIFT | driving frame bits, bit_cnt = bit index currently on the lanes
// S_TAIL  | frame complete, lanes 0 until ad_cs returns high
module ad_responder #(
    parameter int DATA_BITS  = 12,
    parameter int LEAD_ZEROS = 2,
    parameter int FCNT_W     = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    ad_responder_if.slave  bus
);
    localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_TAIL
    } state_t;

    typedef logic [3:0][DATA_BITS-1:0]  set_t;
    typedef logic [3:0][FRAME_BITS-1:0] frame_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_cs_d;
    logic [CNT_W-1:0]  r_bit_cnt;
    frame_t            r_sh;
    logic [3:0]        r_sdata;
    set_t              r_stg;
    logic              r_stg_full;
    set_t              r_last;
    logic              r_frame_done;
    logic              r_underrun;
    logic [FCNT_W-1:0] r_frame_count;
    logic [7:0]        r_abort_count;

    logic              w_start;
    logic              w_abort;
    logic              w_end;
    set_t              w_in;
    set_t              w_load;
    frame_t            w_frame;
    logic              w_no_data;

    // Lane index order: 0=a0, 1=a1, 2=b0, 3=b1
    assign w_in = {bus.sample_b1, bus.sample_b0, bus.sample_a1, bus.sample_a0};

    // Source at frame start: staging, then bypass, then repeat of last set
    assign w_no_data = !r_stg_full && !bus.sample_valid;
    assign w_load    = r_stg_full       ? r_stg :
                       bus.sample_valid ? w_in  : r_last;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_frame[i] = FRAME_BITS'(w_load[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.ad_cs && r_cs_d) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // ad_cs high wins even on the final edge of the frame
                if (bus.ad_cs) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_bit_cnt == LAST_BIT) begin
                    w_end       = 1'b1;
                    w_state_nxt = S_TAIL;
                end
            end
            S_TAIL: begin
                if (bus.ad_cs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_d        <= 1'b1;
            r_bit_cnt     <= '0;
            r_sh          <= '0;
            r_sdata       <= '0;
            r_stg         <= '0;
            r_stg_full    <= 1'b0;
            r_last        <= '0;
            r_frame_done  <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_count <= '0;
            r_abort_count <= '0;
        end else begin
            r_cs_d       <= bus.ad_cs;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;

            if (w_start) begin
                r_last     <= w_load;
                r_bit_cnt  <= '0;
                r_underrun <= w_no_data;
                r_stg_full <= 1'b0;
                for (int i = 0; i < 4; i++) begin
                    r_sdata[i] <= w_frame[i][FRAME_BITS-1];
                    r_sh[i]    <= w_frame[i] << 1;
                end
            end else if (bus.sample_valid && !r_stg_full) begin
                r_stg      <= w_in;
                r_stg_full <= 1'b1;
            end

            if (w_abort) begin
                r_sdata <= '0;
                if (r_abort_count != 8'hFF) begin
                    r_abort_count <= r_abort_count + 8'd1;
                end
            end else if (w_end) begin
                r_sdata       <= '0;
                r_frame_done  <= 1'b1;
                r_frame_count <= r_frame_count + FCNT_W'(1);
            end else if (r_state == S_SHIFT) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                for (int i = 0; i < 4; i++) begin
                    r_sdata[i] <= r_sh[i][FRAME_BITS-1];
                    r_sh[i]    <= r_sh[i] << 1;
                end
            end
        end
    end

    assign bus.ad_sdata_a   = {r_sdata[1], r_sdata[0]};
    assign bus.ad_sdata_b   = {r_sdata[3], r_sdata[2]};
    assign bus.sample_ready = !r_stg_full;
    assign bus.frame_done   = r_frame_done;
    assign bus.underrun     = r_underrun;
    assign bus.frame_count  = r_frame_count;
    assign bus.abort_count  = r_abort_count;
endmodule

// File: tb/tb_ad_responder.sv
// tb_ad_responder
// Directed scenarios followed by randomized ad_cs / sample traffic; a
// frame-level model (bit position within a frame, queue for staging)
// predicts every output, checked on each falling clock edge.
module tb_ad_responder;
    localparam int DB = 12;
    localparam int LZ = 2;
    localparam int FW = 16;
    localparam int FB = DB + LZ;

    typedef logic [3:0][DB-1:0] set_t;
    typedef logic [3:0][FB-1:0] bits_t;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 0;

    ad_responder_if #(.DATA_BITS(DB), .FCNT_W(FW)) bus ();

    ad_responder #(.DATA_BITS(DB), .LEAD_ZEROS(LZ), .FCNT_W(FW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_pos;      // -1 idle, 0..FB-1 bit on lanes, FB tail
    set_t        m_cur;
    set_t        m_last;
    set_t        m_stg[$];
    bit          m_cs_prev;
    bit          m_done;
    bit          m_under;
    logic [FW-1:0] m_fcount;
    int          m_abort;

    task automatic model_reset();
        m_pos = -1;
        m_cur = '0;
        m_last = '0;
        m_stg.delete();
        m_cs_prev = 1'b1;
        m_done = 1'b0;
        m_under = 1'b0;
        m_fcount = '0;
        m_abort = 0;
    endtask

    function automatic logic lane_bit(input int l);
        if (m_pos < LZ || m_pos >= FB) return 1'b0;
        return m_cur[l][DB-1-(m_pos-LZ)];
    endfunction

    always @(negedge reset_n) model_reset();

    always @(posedge clk) begin
        set_t in_set;
        bit   start;
        in_set = {bus.sample_b1, bus.sample_b0, bus.sample_a1, bus.sample_a0};
        if (!reset_n) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            m_under = 1'b0;
            start = 1'b0;
            if (m_pos < 0) begin
                if (!bus.ad_cs && m_cs_prev) start = 1'b1;
            end else if (m_pos < FB) begin
                if (bus.ad_cs) begin
                    m_pos = -1;
                    if (m_abort < 255) m_abort++;
                end else if (m_pos == FB-1) begin
                    m_pos = FB;
                    m_done = 1'b1;
                    m_fcount++;
                end else begin
                    m_pos++;
                end
            end else if (bus.ad_cs) begin
                m_pos = -1;
            end
            if (start) begin
                if (m_stg.size() > 0) m_cur = m_stg.pop_front();
                else if (bus.sample_valid) m_cur = in_set;
                else begin
                    m_cur = m_last;
                    m_under = 1'b1;
                end
                m_last = m_cur;
                m_pos = 0;
            end else if (bus.sample_valid && m_stg.size() == 0) begin
                m_stg.push_back(in_set);
            end
            m_cs_prev = bus.ad_cs;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sdata_a", 32'(bus.ad_sdata_a), 32'({lane_bit(1), lane_bit(0)}));
            chk("sdata_b", 32'(bus.ad_sdata_b), 32'({lane_bit(3), lane_bit(2)}));
            chk("sample_ready", 32'(bus.sample_ready), 32'(m_stg.size() == 0));
            chk("frame_done", 32'(bus.frame_done), 32'(m_done));
            chk("underrun", 32'(bus.underrun), 32'(m_under));
            chk("frame_count", 32'(bus.frame_count), 32'(m_fcount));
            chk("abort_count", 32'(bus.abort_count), 32'(m_abort));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_samples(input logic [DB-1:0] a0, input logic [DB-1:0] a1,
                               input logic [DB-1:0] b0, input logic [DB-1:0] b1);
        bus.sample_a0 = a0;
        bus.sample_a1 = a1;
        bus.sample_b0 = b0;
        bus.sample_b1 = b1;
    endtask

    task automatic push(input logic [DB-1:0] a0, input logic [DB-1:0] a1,
                        input logic [DB-1:0] b0, input logic [DB-1:0] b1);
        set_samples(a0, a1, b0, b1);
        bus.sample_valid = 1'b1;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
    endtask

    // Called just after a rising edge; k=0 is the frame-start edge.
    task automatic run_frame(input int low_cyc, input int drop_k, input int raise_k,
                             output bits_t bits, output int done_k, output int under_k,
                             output int n_done, output logic [31:0] ready_bits);
        bits = '0;
        done_k = -1;
        under_k = -1;
        n_done = 0;
        ready_bits = '0;
        bus.ad_cs = 1'b0;
        for (int k = 0; k < low_cyc; k++) begin
            @(posedge clk); #1;
            if (k == drop_k) bus.sample_valid = 1'b0;
            if (k == raise_k) bus.ad_cs = 1'b1;
            @(negedge clk);
            if (k < FB) begin
                bits[0][FB-1-k] = bus.ad_sdata_a[0];
                bits[1][FB-1-k] = bus.ad_sdata_a[1];
                bits[2][FB-1-k] = bus.ad_sdata_b[0];
                bits[3][FB-1-k] = bus.ad_sdata_b[1];
            end
            if (k < 32) ready_bits[k] = bus.sample_ready;
            if (bus.frame_done) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
            if (bus.underrun && under_k < 0) under_k = k;
        end
        @(posedge clk); #1;
        bus.ad_cs = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bits_t       bits;
        int          done_k, under_k, n_done, cnt;
        logic [31:0] rdy;

        model_reset();
        reset_n = 1'b0;
        bus.ad_cs = 1'b1;
        bus.sample_valid = 1'b0;
        set_samples('0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        chk_en = 1;
        @(negedge clk);
        chk("reset sdata_a", 32'(bus.ad_sdata_a), 0);
        chk("reset ready", 32'(bus.sample_ready), 1);
        chk("reset frame_count", 32'(bus.frame_count), 0);
        @(posedge clk); #1;

        // basic frame
        push(12'hABC, 12'h123, 12'hFFF, 12'h001);
        run_frame(16, -1, -1, bits, done_k, under_k, n_done, rdy);
        chk("t1 a0 bits", 32'(bits[0]), 32'h0ABC);
        chk("t1 a1 bits", 32'(bits[1]), 32'h0123);
        chk("t1 b0 bits", 32'(bits[2]), 32'h0FFF);
        chk("t1 b1 bits", 32'(bits[3]), 32'h0001);
        chk("t1 done edge", 32'(done_k), 14);
        chk("t1 underrun", 32'(under_k), 32'hFFFF_FFFF);
        chk("t1 frame_count", 32'(bus.frame_count), 1);

        // repeat with no new data
        run_frame(16, -1, -1, bits, done_k, under_k, n_done, rdy);
        chk("t2 a0 bits", 32'(bits[0]), 32'h0ABC);
        chk("t2 b1 bits", 32'(bits[3]), 32'h0001);
        chk("t2 underrun edge", 32'(under_k), 0);
        chk("t2 frame_count", 32'(bus.frame_count), 2);

        // bypass at frame start
        set_samples(12'h800, 12'h000, 12'h000, 12'h000);
        bus.sample_valid = 1'b1;
        run_frame(16, 0, -1, bits, done_k, under_k, n_done, rdy);
        chk("t3 a0 bits", 32'(bits[0]), 32'h0800);
        chk("t3 a1 bits", 32'(bits[1]), 0);
        chk("t3 underrun", 32'(under_k), 32'hFFFF_FFFF);
        chk("t3 ready", 32'(rdy[15:0]), 32'hFFFF);

        // staged A, B held off until A consumed
        push(12'h111, 12'h222, 12'h333, 12'h444);
        set_samples(12'h555, 12'h666, 12'h777, 12'h888);
        bus.sample_valid = 1'b1;
        #1;
        chk("t4 ready before", 32'(bus.sample_ready), 0);
        run_frame(16, 1, -1, bits, done_k, under_k, n_done, rdy);
        chk("t4 frame A a0", 32'(bits[0]), 32'h0111);
        chk("t4 frame A b1", 32'(bits[3]), 32'h0444);
        chk("t4 ready seq", 32'(rdy[1:0]), 32'h1);
        run_frame(16, -1, -1, bits, done_k, under_k, n_done, rdy);
        chk("t4 frame B a0", 32'(bits[0]), 32'h0555);
        chk("t4 frame B b1", 32'(bits[3]), 32'h0888);
        chk("t4 frame B underrun", 32'(under_k), 32'hFFFF_FFFF);

        // abort at E0+6, then a long low period yields one frame
        push(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        run_frame(10, -1, 5, bits, done_k, under_k, n_done, rdy);
        chk("t5 abort bits", 32'(bits[0]), 32'h0F00);
        chk("t5 abort_count", 32'(bus.abort_count), 1);
        chk("t5 frame_count", 32'(bus.frame_count), 5);
        chk("t5 no done", 32'(n_done), 0);
        run_frame(30, -1, -1, bits, done_k, under_k, n_done, rdy);
        chk("t5 one frame", 32'(n_done), 1);
        chk("t5 resend bits", 32'(bits[0]), 32'h0FFF);
        chk("t5 underrun", 32'(under_k), 0);

        // reset mid-frame
        push(12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5);
        bus.ad_cs = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset_n = 1'b0;
        bus.ad_cs = 1'b1;
        #1;
        chk("t6 async sdata_a", 32'(bus.ad_sdata_a), 0);
        chk("t6 async sdata_b", 32'(bus.ad_sdata_b), 0);
        chk("t6 ready", 32'(bus.sample_ready), 1);
        chk("t6 frame_count", 32'(bus.frame_count), 0);
        chk("t6 abort_count", 32'(bus.abort_count), 0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_frame(16, -1, -1, bits, done_k, under_k, n_done, rdy);
        chk("t6 underrun", 32'(under_k), 0);
        chk("t6 zero bits", 32'(bits[0] | bits[1] | bits[2] | bits[3]), 0);
        chk("t6 done", 32'(n_done), 1);

        // randomized traffic
        cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            set_samples(DB'($urandom), DB'($urandom), DB'($urandom), DB'($urandom));
            bus.sample_valid = ($urandom_range(0, 2) == 0);
            if (cnt == 0) begin
                bus.ad_cs = ~bus.ad_cs;
                cnt = bus.ad_cs ? $urandom_range(1, 4) : $urandom_range(3, 25);
            end else begin
                cnt--;
            end
            if ($urandom_range(0, 799) == 0) begin
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
            end
        end
        bus.sample_valid = 1'b0;
        bus.ad_cs = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ad_responder.md
Name: ad_responder

Overview:
- Slave-side emulator of the dual-lane serial A/D converter pair that the blaster core reads over ad_cs / ad_sdata_a / ad_sdata_b.
- Serialises four parameterised-width samples (a0, a1, b0, b1) onto the four sdata lanes in response to the reader's chip-select.
- Used for on-board loopback and hardware-in-loop bring-up; data is supplied through a buffered valid/ready handshake, so a pattern generator or host can stream sample sets.

Parameters:
- DATA_BITS, 12, sample width per lane.
- LEAD_ZEROS, 2, leading zero bits driven before the sample MSB.
- FCNT_W, 16, width of frame counter.

Ports:
- clk  in  1  system clock. Same clock as the reader; the reader samples sdata on its sclk (= !clk).
- reset_n  in  1  asynchronous, active-low reset.
- ad_cs  in  1  chip-select from the reader, active low.
- ad_sdata_a  out  2  lane [0] carries a0, lane [1] carries a1.
- ad_sdata_b  out  2  lane [0] carries b0, lane [1] carries b1.
- sample_a0, sample_a1, sample_b0, sample_b1  in  DATA_BITS each  next sample set.
- sample_valid  in  1  sample set present.
- sample_ready  out  1  staging register empty.
- frame_done  out  1  one-cycle pulse when the last data bit has been driven.
- underrun  out  1  one-cycle pulse when a frame starts with no new sample set.
- frame_count  out  FCNT_W  completed frames, wraps.
- abort_count  out  8  frames cut short by ad_cs rising, saturates at 255.

Behaviour:
- Reset (async): all sdata 0; state IDLE; staging empty (sample_ready=1); last-sent registers 0; frame_done=0, underrun=0; both counters 0; cs history register=1.
- cs_d registers ad_cs each clk. The frame-start edge E0 is the first clk edge with ad_cs=0 and cs_d=1.
- States:
  - IDLE: at E0, load shift registers, go to SHIFT, set bit_cnt=0.
  - SHIFT: one bit per edge.
  - TAIL: drive 0 until ad_cs=1, then go to IDLE.
- Bit timing: after E0 each lane drives bit 0. After edge E0+k it drives bit k.
  - Bits 0..LEAD_ZEROS-1 are 0.
  - Bits LEAD_ZEROS..LEAD_ZEROS+DATA_BITS-1 are the sample, MSB first.
  - FRAME_BITS = LEAD_ZEROS+DATA_BITS.
- End of frame: at edge E0+FRAME_BITS the lanes go to 0, the state goes to TAIL, frame_done pulses for one cycle, and frame_count increments.
- Shift-register source at E0, in priority order:
  1. Staging full: load from staging, clear staging.
  2. Staging empty and sample_valid=1 that cycle: bypass, load the input words directly and consume them. No underrun.
  3. Otherwise: reload the last-sent words and pulse underrun.
  - The last-sent registers are updated with whatever was loaded.
- Handshake: sample_ready = staging empty.
  - A transfer occurs when sample_valid & sample_ready, except at E0 where bypass applies.
  - Staging holds one set. Data is captured on the transfer edge.
  - sample_valid may stay high; only one set is taken per ready cycle.
- Abort: ad_cs=1 while in SHIFT means go to IDLE, lanes 0 at the next edge, abort_count increments (saturating). There is no frame_done and no frame_count increment. The loaded set is not re-queued.
- Re-arm: a new frame requires ad_cs to be seen high for at least one edge. ad_cs held low after TAIL produces no further frames.
- All four lanes are bit-aligned. They always share bit_cnt.
- Reset asserted mid-frame: lanes drop to 0 immediately (async). The staging contents are discarded.

Test Plan:
- Reset, then push a0=0xABC, a1=0x123, b0=0xFFF, b1=0x001, then drive ad_cs low for 16 cycles -> lanes show 00 followed by each word MSB first on bits 2..13; frame_done pulses at E0+14; frame_count=1; underrun=0.
- Second frame with no new push -> the same four words are re-sent and underrun pulses once at E0.
- Staging empty and sample_valid=1 coincident with E0, a0=0x800 -> bypass: a0 lane bit 2 =1, rest 0; no underrun; sample_ready stays 1.
- Push set A while idle, then present set B with the frame in progress -> B held off (ready=0) until the E0 that consumes A; B is accepted the next cycle and sent in the following frame.
- ad_cs raised at E0+6 -> lanes 0 from the next edge; abort_count=1; frame_count unchanged. ad_cs held low 30 cycles afterwards -> exactly one frame.
- reset_n pulsed low at E0+8 -> sdata 0 asynchronously; sample_ready=1; counters 0; the next frame reports underrun and sends 0x000.
